// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the PC sequencer slice.
// The optional trap/mret redirect sources are enabled by PC_SEQ_TRAP_EN.
package pc_sequencer_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int PC_WIDTH  = BUS_WIDTH - 2;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_MRET   = 3'd3,
    SRC_TRAP   = 3'd4
  } redirect_src_e;

  // Word increment; wraps silently from all-ones to zero.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(1'b1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake between the PC sequencer (master) and instruction memory (slave).
// Unaffected by PC_SEQ_TRAP_EN.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic fetch_valid_o;
  logic fetch_ready_i;
  pc_t  fetch_addr_o;
  pc_t  pc_o;

  modport master (
    output fetch_valid_o,
    output fetch_addr_o,
    output pc_o,
    input  fetch_ready_i
  );

  modport slave (
    input  fetch_valid_o,
    input  fetch_addr_o,
    input  pc_o,
    output fetch_ready_i
  );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC priority mux: trap, mret, jump, branch, then sequential increment.
// Trap and mret sources exist only when PC_SEQ_TRAP_EN is defined.
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  pc_t           pc,
  input  logic          accept,
  input  logic          branch_taken,
  input  pc_t           branch_target,
  input  logic          jump,
  input  pc_t           jump_target,
`ifdef PC_SEQ_TRAP_EN
  input  logic          trap,
  input  pc_t           mtvec,
  input  logic          mret,
  input  pc_t           mepc,
`endif
  output pc_t           next_pc,
  output redirect_src_e src
);

  // Select the highest-priority redirect; otherwise advance only on acceptance.
  always_comb begin
    next_pc = pc;
    src     = SRC_NONE;
`ifdef PC_SEQ_TRAP_EN
    if (trap) begin
      next_pc = mtvec;
      src     = SRC_TRAP;
    end else if (mret) begin
      next_pc = mepc;
      src     = SRC_MRET;
    end else
`endif
    if (jump) begin
      next_pc = jump_target;
      src     = SRC_JUMP;
    end else if (branch_taken) begin
      next_pc = branch_target;
      src     = SRC_BRANCH;
    end else if (accept) begin
      next_pc = pc_inc(pc);
      src     = SRC_NONE;
    end else begin
      next_pc = pc;
      src     = SRC_NONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/FETCH/HOLD FSM driving the fetch handshake.
// Define PC_SEQ_TRAP_EN to add trap (mtvec) and mret (mepc) redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter pc_t RESET_VEC = {PC_WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  pc_t               branch_target_i,
  input  logic              jump_i,
  input  pc_t               jump_target_i,
`ifdef PC_SEQ_TRAP_EN
  input  logic              trap_i,
  input  logic              mret_i,
  input  pc_t               mtvec_i,
  input  pc_t               mepc_i,
`endif
  pc_sequencer_if.master    fetch
);

  pc_state_e     state_r;
  pc_t           pc_r;
  pc_t           pc_out_r;
  logic          fetch_valid_r;
  pc_t           next_pc_s;
  redirect_src_e src_s;
  logic          accept_s;
  logic          redirect_s;

  assign accept_s   = fetch_valid_r & fetch.fetch_ready_i;
  assign redirect_s = (src_s != SRC_NONE);

  pc_next_mux u_next_mux (
    .pc            (pc_r),
    .accept        (accept_s),
    .branch_taken  (branch_taken_i),
    .branch_target (branch_target_i),
    .jump          (jump_i),
    .jump_target   (jump_target_i),
`ifdef PC_SEQ_TRAP_EN
    .trap          (trap_i),
    .mtvec         (mtvec_i),
    .mret          (mret_i),
    .mepc          (mepc_i),
`endif
    .next_pc       (next_pc_s),
    .src           (src_s)
  );

  // FSM with PC, accepted-PC and fetch_valid all registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= BOOT;
      pc_r          <= RESET_VEC;
      pc_out_r      <= RESET_VEC;
      fetch_valid_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          // Redirects are ignored while booting; the PC stays at the reset vector.
          state_r       <= FETCH;
          fetch_valid_r <= 1'b1;
        end
        FETCH: begin
          if (accept_s) begin
            pc_out_r <= pc_r;
          end else begin
            pc_out_r <= pc_out_r;
          end
          pc_r <= next_pc_s;
          if (stall_i && !redirect_s) begin
            state_r       <= HOLD;
            fetch_valid_r <= 1'b0;
          end else begin
            state_r       <= FETCH;
            fetch_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          pc_r <= next_pc_s;
          if (redirect_s || !stall_i) begin
            state_r       <= FETCH;
            fetch_valid_r <= 1'b1;
          end else begin
            state_r       <= HOLD;
            fetch_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= BOOT;
          fetch_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.fetch_valid_o = fetch_valid_r;
  assign fetch.fetch_addr_o  = pc_r;
  assign fetch.pc_o          = pc_out_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_VEC = 0x10).
// Trap/mret scenario is compiled in only when PC_SEQ_TRAP_EN is defined.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic stall_i;
  logic branch_taken_i;
  pc_t  branch_target_i;
  logic jump_i;
  pc_t  jump_target_i;
`ifdef PC_SEQ_TRAP_EN
  logic trap_i;
  logic mret_i;
  pc_t  mtvec_i;
  pc_t  mepc_i;
`endif

  int tests  = 0;
  int failed = 0;

  pc_sequencer_if fetch_if ();

  pc_sequencer #(.RESET_VEC(30'h10)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
`ifdef PC_SEQ_TRAP_EN
    .trap_i          (trap_i),
    .mret_i          (mret_i),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
`endif
    .fetch           (fetch_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (fetch_if.fetch_valid_o !== 1'b0) begin failed++; $display("FAIL reset_valid: got %0b expected 0", fetch_if.fetch_valid_o); end
    tests++; if (fetch_if.pc_o !== 30'h10) begin failed++; $display("FAIL reset_pc_o: got %h expected 10", fetch_if.pc_o); end
    rst = 1'b0;
    tests++; if (fetch_if.fetch_valid_o !== 1'b0) begin failed++; $display("FAIL boot_valid: got %0b expected 0", fetch_if.fetch_valid_o); end
    tick();
    tests++; if (fetch_if.fetch_valid_o !== 1'b1) begin failed++; $display("FAIL fetch_valid: got %0b expected 1", fetch_if.fetch_valid_o); end
    tests++; if (fetch_if.fetch_addr_o !== 30'h10) begin failed++; $display("FAIL seq0: got %h expected 10", fetch_if.fetch_addr_o); end
    tick();
    tests++; if (fetch_if.fetch_addr_o !== 30'h11) begin failed++; $display("FAIL seq1: got %h expected 11", fetch_if.fetch_addr_o); end
    tests++; if (fetch_if.pc_o !== 30'h10) begin failed++; $display("FAIL seq1_pc_o: got %h expected 10", fetch_if.pc_o); end
    tick();
    tests++; if (fetch_if.fetch_addr_o !== 30'h12) begin failed++; $display("FAIL seq2: got %h expected 12", fetch_if.fetch_addr_o); end
  endtask

  task automatic test_boot_redirect;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    jump_i = 1'b1;
    jump_target_i = 30'h55;
    tick();
    jump_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h10) begin failed++; $display("FAIL boot_redirect: got %h expected 10", fetch_if.fetch_addr_o); end
  endtask

  task automatic test_backpressure;
    fetch_if.fetch_ready_i = 1'b0;
    jump_i = 1'b1;
    jump_target_i = 30'h20;
    tick();
    jump_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h20) begin failed++; $display("FAIL bp_jump: got %h expected 20", fetch_if.fetch_addr_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (fetch_if.fetch_addr_o !== 30'h20 || fetch_if.fetch_valid_o !== 1'b1) begin failed++; $display("FAIL bp_hold%0d: got %h/%0b expected 20/1", i, fetch_if.fetch_addr_o, fetch_if.fetch_valid_o); end
    end
    fetch_if.fetch_ready_i = 1'b1;
    tick();
    tests++; if (fetch_if.fetch_addr_o !== 30'h21) begin failed++; $display("FAIL bp_release: got %h expected 21", fetch_if.fetch_addr_o); end
    tests++; if (fetch_if.pc_o !== 30'h20) begin failed++; $display("FAIL bp_pc_o: got %h expected 20", fetch_if.pc_o); end
  endtask

  task automatic test_simul_redirect;
    fetch_if.fetch_ready_i = 1'b0;
    jump_i = 1'b1;
    jump_target_i = 30'h05;
    tick();
    fetch_if.fetch_ready_i = 1'b1;
    jump_target_i = 30'h40;
    branch_taken_i = 1'b1;
    branch_target_i = 30'h80;
    tick();
    jump_i = 1'b0;
    branch_taken_i = 1'b0;
    fetch_if.fetch_ready_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h40) begin failed++; $display("FAIL simul_addr: got %h expected 40", fetch_if.fetch_addr_o); end
    tests++; if (fetch_if.pc_o !== 30'h05) begin failed++; $display("FAIL simul_pc_o: got %h expected 05", fetch_if.pc_o); end
  endtask

  task automatic test_stall;
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (dut.state_r !== HOLD || fetch_if.fetch_valid_o !== 1'b0 || fetch_if.fetch_addr_o !== 30'h40) begin
        failed++; $display("FAIL stall%0d: got state %0d valid %0b addr %h expected 2/0/40", i, dut.state_r, fetch_if.fetch_valid_o, fetch_if.fetch_addr_o);
      end
    end
    branch_taken_i = 1'b1;
    branch_target_i = 30'h30;
    tick();
    branch_taken_i = 1'b0;
    stall_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h30 || fetch_if.fetch_valid_o !== 1'b1) begin failed++; $display("FAIL stall_branch: got %h/%0b expected 30/1", fetch_if.fetch_addr_o, fetch_if.fetch_valid_o); end
    tick();
    tests++; if (fetch_if.fetch_addr_o !== 30'h30 || fetch_if.fetch_valid_o !== 1'b1) begin failed++; $display("FAIL stall_resume: got %h/%0b expected 30/1", fetch_if.fetch_addr_o, fetch_if.fetch_valid_o); end
  endtask

  task automatic test_wrap;
    fetch_if.fetch_ready_i = 1'b0;
    jump_i = 1'b1;
    jump_target_i = 30'h3FFF_FFFF;
    tick();
    jump_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h3FFF_FFFF) begin failed++; $display("FAIL wrap_setup: got %h expected 3fffffff", fetch_if.fetch_addr_o); end
    fetch_if.fetch_ready_i = 1'b1;
    tick();
    tests++; if (fetch_if.fetch_addr_o !== 30'h0) begin failed++; $display("FAIL wrap_addr: got %h expected 0", fetch_if.fetch_addr_o); end
    tests++; if (fetch_if.pc_o !== 30'h3FFF_FFFF) begin failed++; $display("FAIL wrap_pc_o: got %h expected 3fffffff", fetch_if.pc_o); end
  endtask

  task automatic test_reset_precedence;
    rst = 1'b1;
    jump_i = 1'b1;
    jump_target_i = 30'h77;
    fetch_if.fetch_ready_i = 1'b1;
    tick();
    rst = 1'b0;
    jump_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h10 || fetch_if.pc_o !== 30'h10 || fetch_if.fetch_valid_o !== 1'b0) begin
      failed++; $display("FAIL rst_prec: got %h/%h/%0b expected 10/10/0", fetch_if.fetch_addr_o, fetch_if.pc_o, fetch_if.fetch_valid_o);
    end
    tick();
    tests++; if (fetch_if.fetch_addr_o !== 30'h10 || fetch_if.fetch_valid_o !== 1'b1) begin failed++; $display("FAIL rst_prec_boot: got %h/%0b expected 10/1", fetch_if.fetch_addr_o, fetch_if.fetch_valid_o); end
  endtask

`ifdef PC_SEQ_TRAP_EN
  task automatic test_trap;
    trap_i = 1'b1;
    mtvec_i = 30'h100;
    jump_i = 1'b1;
    jump_target_i = 30'h44;
    fetch_if.fetch_ready_i = 1'b1;
    tick();
    trap_i = 1'b0;
    jump_i = 1'b0;
    fetch_if.fetch_ready_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h100) begin failed++; $display("FAIL trap_addr: got %h expected 100", fetch_if.fetch_addr_o); end
    tests++; if (fetch_if.pc_o !== 30'h10) begin failed++; $display("FAIL trap_pc_o: got %h expected 10", fetch_if.pc_o); end
    mret_i = 1'b1;
    mepc_i = 30'h07;
    branch_taken_i = 1'b1;
    branch_target_i = 30'h99;
    tick();
    mret_i = 1'b0;
    branch_taken_i = 1'b0;
    tests++; if (fetch_if.fetch_addr_o !== 30'h07) begin failed++; $display("FAIL mret_addr: got %h expected 07", fetch_if.fetch_addr_o); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = '0;
    jump_i = 1'b0;
    jump_target_i = '0;
    fetch_if.fetch_ready_i = 1'b1;
`ifdef PC_SEQ_TRAP_EN
    trap_i = 1'b0;
    mret_i = 1'b0;
    mtvec_i = '0;
    mepc_i = '0;
`endif
    test_reset();
    test_boot_redirect();
    test_backpressure();
    test_simul_redirect();
    test_stall();
    test_wrap();
    test_reset_precedence();
`ifdef PC_SEQ_TRAP_EN
    test_trap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
